// File: rtl/job_supervisor_pkg.sv
// job_supervisor_pkg: state encodings and default timing for the go/kill/done job interface
package job_supervisor_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_KILL    = 3'd3,
    S_RECOVER = 3'd4,
    S_REPORT  = 3'd5
  } state_e;
  localparam int DEF_TIMEOUT   = 128;
  localparam int DEF_KILL_HOLD = 4;
  localparam int DEF_RECOVER   = 2;
  localparam int DEF_MAX_RETRY = 2;
  localparam int DEF_RTY_W     = 2;
endpackage

// File: rtl/job_supervisor_cycle_timer.sv
// cycle_timer: clearable up-counter with terminal compare (hit when count == limit-1)
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count_o,
  output logic         hit_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : enable ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
  assign hit_o = count_q == limit - 1'b1;
endmodule

// File: rtl/job_supervisor.sv
// job_supervisor: launches a worker with go, watchdogs done, aborts with kill and retries
module job_supervisor import job_supervisor_pkg::*; #(
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int KILL_HOLD = DEF_KILL_HOLD,
  parameter int RECOVER   = DEF_RECOVER,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int RTY_W     = DEF_RTY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             cancel,
  output logic             go,
  output logic             kill,
  input  logic             done_in,
  output logic             busy,
  output logic             result_valid,
  output logic             result_ok,
  output logic             cancelled,
  output logic [RTY_W-1:0] retries_used
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic cxl_q, cxl_d, ok_q, ok_d, cf_q, cf_d;
  logic go_q, go_d, kill_q, kill_d, busy_q, busy_d, rdy_q, rdy_d, rv_q, rv_d;
  logic [RTY_W-1:0] rty_q, rty_d, ru_q, ru_d;
  logic [TW-1:0] limit, tmr_cnt;
  logic tmr_hit, stop;
  assign limit = state_q == S_WAIT ? TW'(TIMEOUT) : state_q == S_KILL ? TW'(KILL_HOLD) : TW'(RECOVER);
  // one timer serves every timed state: cleared on each state change, held at all-ones
  cycle_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (~&tmr_cnt),
    .limit   (limit),
    .count_o (tmr_cnt),
    .hit_o   (tmr_hit)
  );
  assign stop = cxl_q | cancel | (rty_q == RTY_W'(MAX_RETRY));
  always_comb begin
    state_d = state_q;
    cxl_d = cxl_q;
    rty_d = rty_q;
    ok_d = ok_q;
    cf_d = cf_q;
    ru_d = ru_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_LAUNCH;
        cxl_d = 1'b0;
        rty_d = '0;
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cxl_d = cxl_q | cancel;
      end
      S_WAIT: if (done_in) begin
        state_d = S_REPORT;
        ok_d = 1'b1;
        cf_d = 1'b0;
        ru_d = rty_q;
      end else if (cancel | cxl_q) begin
        state_d = S_KILL;
        cxl_d = 1'b1;
      end else if (tmr_hit) state_d = S_KILL;
      S_KILL: begin
        cxl_d = cxl_q | cancel;
        if (tmr_hit) state_d = S_RECOVER;
      end
      S_RECOVER: begin
        cxl_d = cxl_q | cancel;
        if (tmr_hit && stop) begin
          state_d = S_REPORT;
          ok_d = 1'b0;
          cf_d = cxl_q | cancel;
          ru_d = rty_q;
        end else if (tmr_hit) begin
          state_d = S_LAUNCH;
          rty_d = rty_q + 1'b1;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with state_q
  always_comb begin
    go_d = state_d == S_LAUNCH;
    kill_d = state_d == S_KILL;
    busy_d = state_d != S_IDLE;
    rdy_d = state_d == S_IDLE;
    rv_d = state_d == S_REPORT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cxl_q <= 1'b0;
      rty_q <= '0;
      ok_q <= 1'b0;
      cf_q <= 1'b0;
      ru_q <= '0;
      go_q <= 1'b0;
      kill_q <= 1'b0;
      busy_q <= 1'b0;
      rdy_q <= 1'b1;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cxl_q <= cxl_d;
      rty_q <= rty_d;
      ok_q <= ok_d;
      cf_q <= cf_d;
      ru_q <= ru_d;
      go_q <= go_d;
      kill_q <= kill_d;
      busy_q <= busy_d;
      rdy_q <= rdy_d;
      rv_q <= rv_d;
    end
  assign go = go_q;
  assign kill = kill_q;
  assign busy = busy_q;
  assign req_ready = rdy_q;
  assign result_valid = rv_q;
  assign result_ok = ok_q;
  assign cancelled = cf_q;
  assign retries_used = ru_q;
endmodule

// File: tb/tb_job_supervisor.sv
// tb_job_supervisor: directed scenarios against a worker model with programmable done latency
module tb_job_supervisor;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, cancel = 1'b0, done_in = 1'b0;
  logic req_ready, go, kill, busy, result_valid, result_ok, cancelled;
  logic [1:0] retries_used;
  int total, bad;
  int lat_tab[3];
  int att, wcnt, cur_lat;
  bit wact;
  int cyc, n_go, n_kill, n_rv, last_go, last_kill, last_rv, kill_gap, kill_run;
  bit kill_p;

  job_supervisor dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .cancel(cancel), .go(go), .kill(kill), .done_in(done_in), .busy(busy),
    .result_valid(result_valid), .result_ok(result_ok), .cancelled(cancelled),
    .retries_used(retries_used)
  );

  always #5 clk = ~clk;

  // worker: done_in pulses lat cycles after the go cycle; latency 0 means it hangs
  initial forever begin
    @(negedge clk);
    done_in = 1'b0;
    if (reset || kill) wact = 0;
    else if (wact) begin
      wcnt++;
      if (wcnt == cur_lat) begin
        done_in = 1'b1;
        wact = 0;
      end
    end
    if (go === 1'b1) begin
      wact = 1;
      wcnt = 0;
      cur_lat = lat_tab[att];
      att++;
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (go === 1'b1) begin
      n_go++;
      last_go = cyc;
    end
    if (kill === 1'b1) begin
      if (!kill_p) begin
        kill_gap = cyc - last_go;
        kill_run = 0;
      end
      kill_run++;
      n_kill++;
      last_kill = cyc;
    end
    kill_p = kill === 1'b1;
    if (result_valid === 1'b1) begin
      n_rv++;
      last_rv = cyc;
    end
  end

  task automatic start_job(output int gcyc);
    @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    gcyc = cyc;
  endtask

  task automatic wait_result(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) got = 1;
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, go, kill, busy, result_valid, result_ok, cancelled, retries_used} !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=100000000",
        {req_ready, go, kill, busy, result_valid, result_ok, cancelled, retries_used});
    end
    reset = 1'b0;
  endtask

  task automatic test_done_fast;
    int g, g0, k0;
    bit got;
    lat_tab = '{20, 0, 0};
    att = 0;
    g0 = n_go; k0 = n_kill;
    start_job(g);
    total++;
    if ({go, busy, req_ready} !== 3'b110) begin bad++; $display("FAIL fast_go_cycle got=%b want=110", {go, busy, req_ready}); end
    wait_result(200, got);
    total++;
    if (!got) begin bad++; $display("FAIL fast_result_seen got=0 want=1"); end
    total++;
    if (last_rv - g !== 21) begin bad++; $display("FAIL fast_latency got=%0d want=21", last_rv - g); end
    total++;
    if ({result_ok, cancelled, retries_used} !== 4'b1000) begin bad++; $display("FAIL fast_fields got=%b want=1000", {result_ok, cancelled, retries_used}); end
    total++;
    if (n_go - g0 !== 1 || n_kill - k0 !== 0) begin bad++; $display("FAIL fast_go_kill got=%0d/%0d want=1/0", n_go - g0, n_kill - k0); end
    @(negedge clk);
    total++;
    if ({result_valid, req_ready, busy, result_ok} !== 4'b0101) begin bad++; $display("FAIL fast_after got=%b want=0101", {result_valid, req_ready, busy, result_ok}); end
  endtask

  task automatic test_all_hang;
    int g, g0, k0;
    bit got;
    lat_tab = '{0, 0, 0};
    att = 0;
    g0 = n_go; k0 = n_kill;
    start_job(g);
    wait_result(1000, got);
    total++;
    if (!got) begin bad++; $display("FAIL hang_result_seen got=0 want=1"); end
    total++;
    if (n_go - g0 !== 3 || n_kill - k0 !== 12) begin bad++; $display("FAIL hang_go_kill got=%0d/%0d want=3/12", n_go - g0, n_kill - k0); end
    total++;
    if (kill_gap !== 129 || kill_run !== 4) begin bad++; $display("FAIL hang_windows got=%0d/%0d want=129/4", kill_gap, kill_run); end
    total++;
    if (last_rv - last_kill !== 3) begin bad++; $display("FAIL hang_recover got=%0d want=3", last_rv - last_kill); end
    total++;
    if ({result_ok, cancelled, retries_used} !== 4'b0010) begin bad++; $display("FAIL hang_fields got=%b want=0010", {result_ok, cancelled, retries_used}); end
    repeat (2) @(negedge clk);
    total++;
    if ({result_valid, result_ok, cancelled, retries_used} !== 5'b00010) begin bad++; $display("FAIL hang_hold got=%b want=00010", {result_valid, result_ok, cancelled, retries_used}); end
  endtask

  task automatic test_retry_ok;
    int g, g0, k0;
    bit got;
    lat_tab = '{0, 30, 0};
    att = 0;
    g0 = n_go; k0 = n_kill;
    start_job(g);
    wait_result(600, got);
    total++;
    if (!got) begin bad++; $display("FAIL retry_result_seen got=0 want=1"); end
    total++;
    if (n_go - g0 !== 2 || n_kill - k0 !== 4) begin bad++; $display("FAIL retry_go_kill got=%0d/%0d want=2/4", n_go - g0, n_kill - k0); end
    total++;
    if (last_rv - last_go !== 31) begin bad++; $display("FAIL retry_latency got=%0d want=31", last_rv - last_go); end
    total++;
    if ({result_ok, cancelled, retries_used} !== 4'b1001) begin bad++; $display("FAIL retry_fields got=%b want=1001", {result_ok, cancelled, retries_used}); end
  endtask

  task automatic test_done_at_timeout;
    int g, k0;
    bit got;
    lat_tab = '{128, 0, 0};
    att = 0;
    k0 = n_kill;
    start_job(g);
    wait_result(300, got);
    total++;
    if (!got) begin bad++; $display("FAIL edge_result_seen got=0 want=1"); end
    total++;
    if (n_kill - k0 !== 0) begin bad++; $display("FAIL edge_kill got=%0d want=0", n_kill - k0); end
    total++;
    if (last_rv - g !== 129) begin bad++; $display("FAIL edge_latency got=%0d want=129", last_rv - g); end
    total++;
    if ({result_ok, cancelled, retries_used} !== 4'b1000) begin bad++; $display("FAIL edge_fields got=%b want=1000", {result_ok, cancelled, retries_used}); end
  endtask

  task automatic test_cancel;
    int g, g0, k0;
    bit got;
    lat_tab = '{0, 0, 0};
    att = 0;
    g0 = n_go; k0 = n_kill;
    start_job(g);
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_result(100, got);
    total++;
    if (!got) begin bad++; $display("FAIL cancel_result_seen got=0 want=1"); end
    total++;
    if (n_go - g0 !== 1 || n_kill - k0 !== 4) begin bad++; $display("FAIL cancel_go_kill got=%0d/%0d want=1/4", n_go - g0, n_kill - k0); end
    total++;
    if (kill_gap !== 12 || last_rv - last_kill !== 3) begin bad++; $display("FAIL cancel_timing got=%0d/%0d want=12/3", kill_gap, last_rv - last_kill); end
    total++;
    if ({result_ok, cancelled, retries_used} !== 4'b0100) begin bad++; $display("FAIL cancel_fields got=%b want=0100", {result_ok, cancelled, retries_used}); end
  endtask

  task automatic test_reset_in_kill;
    int g, r0;
    bit got;
    lat_tab = '{0, 0, 0};
    att = 0;
    start_job(g);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (kill === 1'b1) got = 1;
    end
    total++;
    if (!got) begin bad++; $display("FAIL rst_kill_seen got=0 want=1"); end
    @(negedge clk);
    r0 = n_rv;
    reset = 1'b1;
    #1;
    total++;
    if ({go, kill, busy, req_ready} !== 4'b0001) begin bad++; $display("FAIL rst_async got=%b want=0001", {go, kill, busy, req_ready}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || n_rv !== r0) begin bad++; $display("FAIL rst_no_result got=%b/%0d want=1/%0d", req_ready, n_rv, r0); end
    lat_tab = '{20, 0, 0};
    att = 0;
    start_job(g);
    wait_result(200, got);
    total++;
    if (!got || last_rv - g !== 21 || {result_ok, cancelled, retries_used} !== 4'b1000) begin
      bad++;
      $display("FAIL rst_new_job got=%0d/%0d/%b want=1/21/1000", got, last_rv - g, {result_ok, cancelled, retries_used});
    end
  endtask

  initial begin
    test_reset;
    test_done_fast;
    test_all_hang;
    test_retry_ok;
    test_done_at_timeout;
    test_cancel;
    test_reset_in_kill;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
